// File: rtl/ksm_pkg.sv
// Shared types for the sequential Karatsuba multiplier: FSM states and the
// operand-select encoding for the shared multiplier.
package ksm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_HH  = 3'd1,
    MUL_LL  = 3'd2,
    MUL_MID = 3'd3,
    COMBINE = 3'd4,
    OUT     = 3'd5
  } ksm_state_t;

  typedef enum logic [1:0] {
    SEL_HH  = 2'd0,
    SEL_LL  = 2'd1,
    SEL_MID = 2'd2
  } ksm_sel_t;

endpackage

// File: rtl/ksm_mul_unit.sv
// Operand mux plus the single (HALF_W+1)x(HALF_W+1) unsigned multiplier that is
// time-shared across the three Karatsuba partial products. Purely combinational.
module ksm_mul_unit
  import ksm_pkg::*;
#(
  parameter int HALF_W = 8
) (
  input  ksm_sel_t              sel,
  input  logic [HALF_W-1:0]     ah,
  input  logic [HALF_W-1:0]     al,
  input  logic [HALF_W-1:0]     bh,
  input  logic [HALF_W-1:0]     bl,
  output logic [2*HALF_W+1:0]   prod
);

  logic [HALF_W:0] op_a;
  logic [HALF_W:0] op_b;

  always_comb begin
    op_a = {1'b0, ah};
    op_b = {1'b0, bh};
    case (sel)
      SEL_LL: begin
        op_a = {1'b0, al};
        op_b = {1'b0, bl};
      end
      SEL_MID: begin
        // half sums carry into bit HALF_W, hence the extra operand bit
        op_a = {1'b0, ah} + {1'b0, al};
        op_b = {1'b0, bh} + {1'b0, bl};
      end
      default: ;
    endcase
  end

  assign prod = (2*HALF_W+2)'(op_a) * (2*HALF_W+2)'(op_b);

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// Sequential Karatsuba multiplier controller with valid/ready on both sides.
// Optional macro KSM_FASTPATH_EN: operands with zero upper halves skip MUL_HH/MUL_MID.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready=1
// MUL_HH  | p_hh <= ah*bh
// MUL_LL  | p_ll <= al*bl (fast path also fixes p_hh/p_mid here)
// MUL_MID | p_mid <= (ah+al)*(bh+bl)
// COMBINE | product <= recombined partial products
// OUT     | out_valid=1, hold product until out_ready
module karatsuba_seq_ctrl
  import ksm_pkg::*;
#(
  parameter int HALF_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*HALF_W-1:0]   a_in,
  input  logic [2*HALF_W-1:0]   b_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*HALF_W-1:0]   product,
  output logic                  busy
);

  localparam int OW = 2 * HALF_W;
  localparam int MW = 2 * HALF_W + 2;
  localparam int PW = 4 * HALF_W;

  ksm_state_t        state, nxt;
  ksm_sel_t          sel;
  logic              ld_ops, ld_hh, ld_ll, ld_mid, ld_prod;
  logic [OW-1:0]     a_r, b_r;
  logic [MW-1:0]     p_hh, p_ll, p_mid, mul_p, mid_term;
  logic [PW-1:0]     prod_nxt;
`ifdef KSM_FASTPATH_EN
  logic              ld_fast;
`endif

  ksm_mul_unit #(.HALF_W(HALF_W)) u_mul (
    .sel  (sel),
    .ah   (a_r[OW-1:HALF_W]),
    .al   (a_r[HALF_W-1:0]),
    .bh   (b_r[OW-1:HALF_W]),
    .bl   (b_r[HALF_W-1:0]),
    .prod (mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt     = state;
    sel     = SEL_HH;
    ld_ops  = 1'b0;
    ld_hh   = 1'b0;
    ld_ll   = 1'b0;
    ld_mid  = 1'b0;
    ld_prod = 1'b0;
`ifdef KSM_FASTPATH_EN
    ld_fast = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          ld_ops = 1'b1;
          nxt    = MUL_HH;
`ifdef KSM_FASTPATH_EN
          if (a_in[OW-1:HALF_W] == '0 && b_in[OW-1:HALF_W] == '0) nxt = MUL_LL;
`endif
        end
      end
      MUL_HH: begin
        sel   = SEL_HH;
        ld_hh = 1'b1;
        nxt   = MUL_LL;
      end
      MUL_LL: begin
        sel   = SEL_LL;
        ld_ll = 1'b1;
        nxt   = MUL_MID;
`ifdef KSM_FASTPATH_EN
        // only fast-path operations can reach here with both upper halves zero
        if (a_r[OW-1:HALF_W] == '0 && b_r[OW-1:HALF_W] == '0) begin
          ld_fast = 1'b1;
          nxt     = COMBINE;
        end
`endif
      end
      MUL_MID: begin
        sel    = SEL_MID;
        ld_mid = 1'b1;
        nxt    = COMBINE;
      end
      COMBINE: begin
        ld_prod = 1'b1;
        nxt     = OUT;
      end
      OUT: begin
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // (ah+al)(bh+bl) - ah*bh - al*bl = ah*bl + al*bh, never negative
  assign mid_term = p_mid - p_hh - p_ll;
  assign prod_nxt = (PW'(p_hh) << OW) + (PW'(mid_term) << HALF_W) + PW'(p_ll);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      p_hh    <= '0;
      p_ll    <= '0;
      p_mid   <= '0;
      product <= '0;
    end else begin
      if (ld_ops) begin
        a_r <= a_in;
        b_r <= b_in;
      end
      if (ld_hh)   p_hh    <= mul_p;
      if (ld_ll)   p_ll    <= mul_p;
      if (ld_mid)  p_mid   <= mul_p;
`ifdef KSM_FASTPATH_EN
      if (ld_fast) begin
        p_hh  <= '0;
        p_mid <= mul_p;
      end
`endif
      if (ld_prod) product <= prod_nxt;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Scoreboard bench for karatsuba_seq_ctrl (HALF_W=8): driver pushes a*b and the
// expected latency, monitor pops and compares on every output handshake.
module tb_karatsuba_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] product;
  logic        busy;

  int total = 0;
  int bad = 0;
  int rdy_mode = 1;  // 0 random, 1 always high, 2 always low

  typedef struct {
    logic [31:0] prod;
    int          lat;
    time         t_acc;
  } exp_t;
  exp_t exp_q[$];

  karatsuba_seq_ctrl #(.HALF_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
`ifdef KSM_FASTPATH_EN
    if (a[15:8] == 8'h00 && b[15:8] == 8'h00) return 2;
`endif
    return 4;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // chk: also verify in_ready stays low through the whole operation (needs rdy_mode=1)
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit chk);
    bit acc = 0;
    int waitc = 0;
    int lat = exp_lat(a, b);
    @(posedge clk);
    #1;
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      waitc++;
      if (!acc && waitc > 200) begin
        check("accept_timeout", 64'(waitc), 64'd0);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back('{prod: 32'(a) * 32'(b), lat: lat, t_acc: $time});
    #1;
    in_valid = 1'b0;
    a_in = 16'($urandom);
    b_in = 16'($urandom);
    if (chk) begin
      for (int i = 0; i <= lat + 1; i++) begin
        @(negedge clk);
        check("in_ready_seq", 64'(in_ready), (i == lat + 1) ? 64'd1 : 64'd0);
      end
    end
  endtask

  initial begin : monitor
    bit seen = 0;
    logic [31:0] held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
        continue;
      end
      check("ready_vs_busy", 64'(in_ready), 64'(!busy));
      if (out_valid) begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 64'd1, 64'd0);
          end else begin
            check("product", 64'(product), 64'(exp_q[0].prod));
            check("latency", 64'(($time - 5 - exp_q[0].t_acc) / 10), 64'(exp_q[0].lat));
          end
          seen = 1;
          held = product;
        end else begin
          check("product_hold", 64'(product), 64'(held));
        end
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    logic [15:0] a, b;

    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    #3;
    rst_n = 1'b1;

    rdy_mode = 1;
    issue(16'h1234, 16'h5678, 1);
    issue(16'hFFFF, 16'hFFFF, 1);
    issue(16'h00FF, 16'h0003, 1);
    issue(16'hABCD, 16'h0000, 1);
    issue(16'h0000, 16'h0000, 1);
    issue(16'h0001, 16'hFF00, 1);

    // stall in OUT with ignored in_valid pulses
    rdy_mode = 2;
    issue(16'hBEEF, 16'h1357, 0);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("stall_reach_out", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      a_in = 16'($urandom);
      b_in = 16'($urandom);
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_busy", 64'(busy), 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdy_mode = 1;
    repeat (3) @(posedge clk);

    // reset during MUL_MID discards the operation
    issue(16'h1234, 16'h5678, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_product", 64'(product), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    issue(16'h0002, 16'h0003, 1);

    // randomized traffic with random back-pressure
    rdy_mode = 0;
    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        a[15:8] = 8'h00;
        b[15:8] = 8'h00;
      end
      issue(a, b, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
